dts_deframe_lock: RTL and testbench

//  Per-link DTS deframer/lock monitor on the GT receive clock. Checks each 160-bit received word for a valid

---
 rtl/dts_pkg.sv | 42 ++++
 rtl/dts_deframe_lock_if.sv | 33 +++
 rtl/dts_deframe_lock.sv | 165 ++++++++++++++++
 tb/tb_dts_deframe_lock.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dts_pkg.sv
// Shared DTS definitions: sync word, overhead bit positions, lock FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package dts_pkg;

    // Raw word layout: [159:144] sync, [143:136] frame count, [135:132] flags, [127:0] payload
    localparam int DTS_IN_W  = 160;
    localparam int DTS_OUT_W = 128;
    localparam int DTS_ERR_W = 16;

    localparam logic [15:0] DTS_SYNC_WORD = 16'hF628;

    localparam int SYNC_MSB    = 159;
    localparam int SYNC_LSB    = 144;
    localparam int FC_MSB      = 143;
    localparam int FC_LSB      = 136;
    localparam int ONE_SEC_BIT = 135;
    localparam int TEN_SEC_BIT = 134;
    localparam int INDEX_BIT   = 133;
    localparam int SYNC_BIT    = 132;

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_FLYWHEEL = 2'd3
    } dts_state_e;

    // Overhead flags in the same bit order as they sit in the raw word
    typedef struct packed {
        logic one_sec;
        logic ten_sec;
        logic index;
        logic sync;
    } dts_flags_t;

    // Expected successor of a frame count; 255 wraps to 0
    function automatic logic [7:0] dts_next_fc(input logic [7:0] fc);
        return fc + 8'd1;
    endfunction

endpackage

// File: rtl/dts_deframe_lock_if.sv
// Receive-side bundle between the GT word source and the deframer.
// Latency: n/a (wires only).
// Backpressure: none; din_valid qualifies each word, the sink never stalls.
interface dts_deframe_lock_if
    import dts_pkg::*;
#(
    parameter int IW = DTS_IN_W,
    parameter int OW = DTS_OUT_W,
    parameter int EW = DTS_ERR_W
);
    logic [IW-1:0] din;
    logic          din_valid;
    logic          err_clr;
    logic [OW-1:0] dout;
    logic          dout_locked;
    logic          dout_one_sec;
    logic          dout_ten_sec;
    logic          dout_index;
    logic          dout_sync;
    logic [EW-1:0] err_count;

    // Word source side
    modport master (
        output din, din_valid, err_clr,
        input  dout, dout_locked, dout_one_sec, dout_ten_sec, dout_index, dout_sync, err_count
    );

    // Deframer side
    modport slave (
        input  din, din_valid, err_clr,
        output dout, dout_locked, dout_one_sec, dout_ten_sec, dout_index, dout_sync, err_count
    );
endinterface

// File: rtl/dts_deframe_lock.sv
// Per-link DTS deframer: checks sync/frame-count overhead, hunt/check/lock/flywheel, emits payload + flags.
// Latency: 1 clk din->dout; dout_locked shows the state after that same word.
// Backpressure: none; idle (din_valid low) cycles freeze state and hold outputs.
module dts_deframe_lock
    import dts_pkg::*;
#(
    parameter int          INPUT_DWIDTH  = DTS_IN_W,
    parameter int          OUTPUT_DWIDTH = DTS_OUT_W,
    parameter logic [15:0] SYNC_WORD     = DTS_SYNC_WORD,
    parameter int          LOCK_COUNT    = 8,
    parameter int          UNLOCK_COUNT  = 4,
    parameter int          ERR_WIDTH     = DTS_ERR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    dts_deframe_lock_if.slave rx
);

    // good_cnt never needs to hold LOCK_COUNT itself (lock is taken on the word that would reach it);
    // likewise bad_cnt is cleared on the word that reaches UNLOCK_COUNT.
    localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int BW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;

    logic [INPUT_DWIDTH-1:0]  din_w;
    logic [7:0]               fc_in;
    logic                     sync_match;
    logic                     good;
    dts_flags_t               flags_in;
    logic                     unused_rsvd;

    dts_state_e               state_q, state_d;
    logic [GW-1:0]            good_cnt_q, good_cnt_d;
    logic [BW-1:0]            bad_cnt_q, bad_cnt_d;
    logic [7:0]               last_fc_q, last_fc_d;
    logic                     err_inc;
    logic [ERR_WIDTH-1:0]     err_q, err_d;
    logic [OUTPUT_DWIDTH-1:0] dout_q, dout_d;
    dts_flags_t               flags_q, flags_d;
    logic                     locked_q, locked_d;

    assign din_w       = rx.din;
    assign fc_in       = din_w[FC_MSB:FC_LSB];
    assign flags_in    = dts_flags_t'(din_w[ONE_SEC_BIT:SYNC_BIT]);
    assign sync_match  = (din_w[SYNC_MSB:SYNC_LSB] == SYNC_WORD);
    assign good        = sync_match && (fc_in == dts_next_fc(last_fc_q));
    // Overhead bits [131:128] carry nothing this block consumes
    assign unused_rsvd = ^din_w[131:128];

    // Next-state for the lock FSM, frame-count tracker and registered outputs; all frozen on idle cycles
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        last_fc_d  = last_fc_q;
        err_inc    = 1'b0;
        dout_d     = dout_q;
        flags_d    = flags_q;
        locked_d   = locked_q;

        if (rx.din_valid) begin
            // Any sync-matching word re-anchors continuity, even a discontinuous one
            if (sync_match) begin
                last_fc_d = fc_in;
            end

            case (state_q)
                ST_HUNT: begin
                    if (sync_match) begin
                        state_d    = ST_CHECK;
                        good_cnt_d = GW'(1);
                    end
                end
                ST_CHECK: begin
                    if (!good) begin
                        state_d    = ST_HUNT;
                        good_cnt_d = '0;
                    end else if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!good) begin
                        err_inc = 1'b1;
                        if (UNLOCK_COUNT == 1) begin
                            state_d   = ST_HUNT;
                            bad_cnt_d = '0;
                        end else begin
                            state_d   = ST_FLYWHEEL;
                            bad_cnt_d = BW'(1);
                        end
                    end
                end
                ST_FLYWHEEL: begin
                    if (good) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = '0;
                    end else begin
                        err_inc = 1'b1;
                        if (bad_cnt_q == BW'(UNLOCK_COUNT - 1)) begin
                            state_d   = ST_HUNT;
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BW'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            endcase

            // Outputs follow the post-update state; bad words still pass through while flywheeling
            locked_d = (state_d == ST_LOCKED) || (state_d == ST_FLYWHEEL);
            dout_d   = locked_d ? din_w[OUTPUT_DWIDTH-1:0] : '0;
            flags_d  = locked_d ? flags_in : '0;
        end
    end

    // Saturating error counter; a clear wins over a same-cycle increment
    always_comb begin
        err_d = err_q;
        if (rx.err_clr) begin
            err_d = '0;
        end else if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_WIDTH'(1);
        end
    end

    // State and output registers; reset drops straight back to hunt with all outputs cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            last_fc_q  <= '0;
            err_q      <= '0;
            dout_q     <= '0;
            flags_q    <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            last_fc_q  <= last_fc_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            flags_q    <= flags_d;
            locked_q   <= locked_d;
        end
    end

    assign rx.dout         = dout_q;
    assign rx.dout_locked  = locked_q;
    assign rx.dout_one_sec = flags_q.one_sec;
    assign rx.dout_ten_sec = flags_q.ten_sec;
    assign rx.dout_index   = flags_q.index;
    assign rx.dout_sync    = flags_q.sync;
    assign rx.err_count    = err_q;

endmodule

// File: tb/tb_dts_deframe_lock.sv
// Self-checking bench for dts_deframe_lock: vector table, directed corner sequences, random run vs model.
// Latency: expects outputs one clock after each driven word.
// Backpressure: none; bench drives idle cycles through din_valid.
module tb_dts_deframe_lock;
    import dts_pkg::*;

    localparam int LOCK_N   = 8;
    localparam int UNLOCK_N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance plus a narrow-counter twin sharing the same stimulus so saturation is reachable quickly
    dts_deframe_lock_if #(.EW(16)) bus ();
    dts_deframe_lock_if #(.EW(4))  sbus ();

    assign sbus.din       = bus.din;
    assign sbus.din_valid = bus.din_valid;
    assign sbus.err_clr   = bus.err_clr;

    dts_deframe_lock #(.ERR_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.slave)
    );

    dts_deframe_lock #(.ERR_WIDTH(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (sbus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: acquisition run length, consecutive misses while locked, last anchored count
    bit         m_locked;
    int         m_run;
    int         m_miss;
    logic [7:0] m_last;
    int         m_err;
    int         m_err4;
    logic [127:0] e_dout;
    logic [3:0]   e_flags;
    logic         e_locked;

    typedef struct {
        logic       vld;
        logic [7:0] fc;
        logic       sync_ok;
        logic       exp_locked;
        int         exp_err;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [159:0] mk_word(input logic sync_ok, input logic [7:0] fc,
                                             input logic [3:0] flags, input logic [127:0] pay);
        logic [15:0] sw;
        sw = sync_ok ? DTS_SYNC_WORD : (DTS_SYNC_WORD ^ 16'h0101);
        return {sw, fc, flags, 4'h0, pay};
    endfunction

    function automatic logic [127:0] mk_pay(input int i);
        logic [31:0] base;
        base = 32'hC0DE0000 + 32'(i);
        return {base, ~base, base ^ 32'h5A5A5A5A, base + 32'h11};
    endfunction

    task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        cmp({name, ".dout"},   bus.dout, e_dout);
        cmp({name, ".flags"},  {bus.dout_one_sec, bus.dout_ten_sec, bus.dout_index, bus.dout_sync}, e_flags);
        cmp({name, ".locked"}, bus.dout_locked, e_locked);
        cmp({name, ".err"},    bus.err_count, m_err);
        cmp({name, ".err4"},   sbus.err_count, m_err4);
        cmp({name, ".locked4"}, sbus.dout_locked, e_locked);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_run    = 0;
        m_miss   = 0;
        m_last   = 8'd0;
        m_err    = 0;
        m_err4   = 0;
        e_dout   = '0;
        e_flags  = '0;
        e_locked = 1'b0;
    endtask

    task automatic model_update(input logic vld, input logic [159:0] w, input logic clr);
        logic       sm;
        logic       good;
        logic [7:0] fc;
        bit         bump;
        bump = 1'b0;
        if (vld) begin
            fc   = w[143:136];
            sm   = (w[159:144] == DTS_SYNC_WORD);
            good = sm && (fc == 8'((int'(m_last) + 1) % 256));
            if (sm) m_last = fc;
            if (!m_locked) begin
                if (m_run == 0) begin
                    m_run = sm ? 1 : 0;
                end else if (good) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_locked = 1'b1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (good) begin
                m_miss = 0;
            end else begin
                bump = 1'b1;
                m_miss++;
                if (m_miss == UNLOCK_N) begin
                    m_locked = 1'b0;
                    m_miss   = 0;
                end
            end
            e_locked = m_locked;
            e_dout   = m_locked ? w[127:0] : '0;
            e_flags  = m_locked ? w[135:132] : '0;
        end
        if (clr) begin
            m_err  = 0;
            m_err4 = 0;
        end else if (bump) begin
            if (m_err < 65535) m_err++;
            if (m_err4 < 15)   m_err4++;
        end
    endtask

    task automatic step(input logic vld, input logic [159:0] w, input logic clr, input string name);
        @(negedge clk);
        bus.din_valid = vld;
        bus.din       = w;
        bus.err_clr   = clr;
        model_update(vld, w, clr);
        @(posedge clk);
        #1;
        check_all(name);
    endtask

    // Asserted away from any clock edge so only an asynchronous clear can pass the check
    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        bus.err_clr   = 1'b0;
        bus.din       = '0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_good(input int i, input string name);
        step(1'b1, mk_word(1'b1, 8'((int'(m_last) + 1) % 256), 4'(i), mk_pay(i)), 1'b0, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] w;
        logic [7:0]   fc;
        logic         vld;
        logic         sok;
        logic         clr;
        int           r;

        bus.din_valid = 1'b0;
        bus.err_clr   = 1'b0;
        bus.din       = '0;
        model_reset();

        // Lock from reset, one wrong-sync word while locked, an idle cycle, then continuity resumes
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{vld: 1'b1, fc: 8'(i), sync_ok: 1'b1, exp_locked: (i >= 7), exp_err: 0};
        end
        vecs[10] = '{vld: 1'b1, fc: 8'd10, sync_ok: 1'b0, exp_locked: 1'b1, exp_err: 1};
        vecs[11] = '{vld: 1'b1, fc: 8'd10, sync_ok: 1'b1, exp_locked: 1'b1, exp_err: 1};
        vecs[12] = '{vld: 1'b0, fc: 8'd99, sync_ok: 1'b0, exp_locked: 1'b1, exp_err: 1};
        vecs[13] = '{vld: 1'b1, fc: 8'd11, sync_ok: 1'b1, exp_locked: 1'b1, exp_err: 1};

        apply_reset();
        for (int i = 0; i < 14; i++) begin
            w = mk_word(vecs[i].sync_ok, vecs[i].fc, 4'(i), mk_pay(i));
            step(vecs[i].vld, w, 1'b0, "tbl");
            cmp("tbl.exp_locked", bus.dout_locked, vecs[i].exp_locked);
            cmp("tbl.exp_err", bus.err_count, vecs[i].exp_err);
        end

        // Four consecutive bad words drop lock on the fourth; count cleared first
        step(1'b1, mk_word(1'b1, 8'd12, 4'h3, mk_pay(40)), 1'b1, "clr_good");
        cmp("clr_good.err0", bus.err_count, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk_word(1'b0, 8'd13, 4'hF, mk_pay(50 + i)), 1'b0, "unlock");
            cmp("unlock.locked", bus.dout_locked, (i < 3));
            cmp("unlock.err", bus.err_count, 16'(i + 1));
        end
        step(1'b1, mk_word(1'b1, 8'd13, 4'hF, mk_pay(60)), 1'b0, "after_unlock");
        cmp("after_unlock.dout0", bus.dout, 128'd0);

        // Frame count wrapping 255 -> 0 is continuous
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            fc = 8'((248 + i) % 256);
            step(1'b1, mk_word(1'b1, fc, 4'(i), mk_pay(100 + i)), 1'b0, "wrap");
        end
        cmp("wrap.locked", bus.dout_locked, 1'b1);
        cmp("wrap.err", bus.err_count, 16'd0);

        // Idle gap inside acquisition keeps the accumulated good-word run
        apply_reset();
        for (int i = 0; i < 4; i++) send_good(200 + i, "gap_pre");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, mk_word(1'b1, 8'd4, 4'hA, mk_pay(300 + i)), 1'b0, "gap_idle");
        end
        for (int i = 0; i < 3; i++) send_good(210 + i, "gap_post");
        cmp("gap.locked_7th", bus.dout_locked, 1'b0);
        send_good(213, "gap_8th");
        cmp("gap.locked_8th", bus.dout_locked, 1'b1);

        // Reset while locked, then saturate the narrow counter and clear it on a bad word
        send_good(214, "pre_rst");
        apply_reset();
        cmp("rst.locked", bus.dout_locked, 1'b0);
        for (int i = 0; i < 8; i++) send_good(400 + i, "relock");
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, mk_word(1'b0, 8'hEE, 4'h5, mk_pay(500 + i)), 1'b0, "sat_bad");
            end
            send_good(600 + g, "sat_good");
        end
        cmp("sat.err4", sbus.err_count, 4'hF);
        cmp("sat.err16", bus.err_count, 16'd18);
        step(1'b1, mk_word(1'b0, 8'hEE, 4'h5, mk_pay(700)), 1'b1, "sat_clr");
        cmp("sat_clr.err4", sbus.err_count, 4'h0);
        cmp("sat_clr.err16", bus.err_count, 16'd0);

        // Random traffic against the model
        apply_reset();
        for (int n = 0; n < 4000; n++) begin
            vld = ($urandom_range(0, 7) != 0);
            r   = int'($urandom_range(0, 31));
            sok = (r != 0);
            fc  = (r == 1) ? 8'($urandom_range(0, 255)) : 8'((int'(m_last) + 1) % 256);
            clr = ($urandom_range(0, 99) == 0);
            w   = mk_word(sok, fc, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
            step(vld, w, clr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
